// File: rtl/accl_pair_scheduler.sv
// rtl/accl_pair_scheduler.sv - n-body pair scheduler feeding the getAccl pipeline
module accl_pair_scheduler #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 122
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   n_bodies,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_x,
  input  logic [63:0]       rd_y,
  input  logic [63:0]       rd_m,
  output logic [63:0]       x1,
  output logic [63:0]       y1,
  output logic [63:0]       x2,
  output logic [63:0]       y2,
  output logic [63:0]       m2,
  output logic              in_valid,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_target,
  output logic              out_first,
  output logic              out_last
);

  localparam int CW = ADDR_W + 1;
  // tag layout: {valid, target, first, last}
  localparam int TW = ADDR_W + 3;
  localparam logic [CW-1:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_TGT, STREAM, DRAIN, DONE} state_t;

  state_t state, nxt;

  logic [CW-1:0]     n_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] j_q;
  logic [CW-1:0]     cnt_q;

  logic [CW-1:0]     n_clamped;
  logic              last_j;
  logic              last_i;
  logic [ADDR_W-1:0] j_inc;
  logic [ADDR_W-1:0] j_nxt;

  // read-slot stage: what the RAM is returning this cycle
  logic              p1_valid;
  logic              p1_tgt;
  logic [ADDR_W-1:0] p1_i;
  logic              p1_first;
  logic              p1_last;

  logic [63:0]       sh_x;
  logic [63:0]       sh_y;
  logic [TW-1:0]     tag_q;
  logic [TW-1:0]     dl [LATENCY];
  logic              pipe_busy;

  assign n_clamped = (n_bodies > MAX_N) ? MAX_N : n_bodies;
  assign last_j    = (cnt_q == n_q - CW'(2));
  assign last_i    = ({1'b0, i_q} == n_q - CW'(1));
  // j wraps in ADDR_W bits only on the last source, where it is never used
  assign j_inc     = j_q + ADDR_W'(1);
  assign j_nxt     = (j_inc == i_q) ? j_q + ADDR_W'(2) : j_inc;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state and control outputs
  always_comb begin
    nxt     = state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_addr = '0;
    case (state)
      IDLE: begin
        if (start) nxt = (n_clamped < CW'(2)) ? DONE : LOAD_TGT;
      end
      LOAD_TGT: begin
        busy    = 1'b1;
        rd_addr = i_q;
        nxt     = STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        rd_addr = j_q;
        if (last_j) nxt = last_i ? DRAIN : LOAD_TGT;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // body count and target/source index counters
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q <= n_clamped;
            i_q <= '0;
          end
        end
        LOAD_TGT: begin
          j_q   <= (i_q == '0) ? ADDR_W'(1) : '0;
          cnt_q <= '0;
        end
        STREAM: begin
          if (!last_j) begin
            j_q   <= j_nxt;
            cnt_q <= cnt_q + CW'(1);
          end else if (!last_i) begin
            i_q <= i_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // follow the address one cycle to line up with RAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_tgt   <= 1'b0;
      p1_i     <= '0;
      p1_first <= 1'b0;
      p1_last  <= 1'b0;
    end else begin
      p1_valid <= (state == STREAM);
      p1_tgt   <= (state == LOAD_TGT);
      p1_i     <= i_q;
      p1_first <= (cnt_q == '0);
      p1_last  <= last_j;
    end
  end

  // target shadow, pair output registers and tag; bubbles hold x1..m2
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x     <= '0;
      sh_y     <= '0;
      x1       <= '0;
      y1       <= '0;
      x2       <= '0;
      y2       <= '0;
      m2       <= '0;
      in_valid <= 1'b0;
      tag_q    <= '0;
    end else begin
      if (p1_tgt) begin
        sh_x <= rd_x;
        sh_y <= rd_y;
      end
      if (p1_valid) begin
        x1 <= sh_x;
        y1 <= sh_y;
        x2 <= rd_x;
        y2 <= rd_y;
        m2 <= rd_m;
      end
      in_valid <= p1_valid;
      tag_q    <= p1_valid ? {1'b1, p1_i, p1_first, p1_last} : '0;
    end
  end

  // tag delay line matching the getAccl latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) dl[k] <= '0;
    end else begin
      dl[0] <= tag_q;
      for (int k = 1; k < LATENCY; k++) dl[k] <= dl[k-1];
    end
  end

  // any valid tag still upstream of the final stage
  always_comb begin
    pipe_busy = p1_valid | tag_q[TW-1];
    for (int k = 0; k < LATENCY - 1; k++) pipe_busy = pipe_busy | dl[k][TW-1];
  end

  assign out_valid  = dl[LATENCY-1][TW-1];
  assign out_target = dl[LATENCY-1][TW-2:2];
  assign out_first  = dl[LATENCY-1][1];
  assign out_last   = dl[LATENCY-1][0];

endmodule
